// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: return-tag owner encoding,
// PPU drawing mode value, lockout read data and the fixed read latency.
package vram_arb_pkg;

  localparam int         RD_LAT     = 2;
  localparam logic [1:0] MODE_DRAW  = 2'd3;
  localparam logic [7:0] LOCK_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PPU  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   is_read;
    logic   lock_rd;
  } rtag_t;

endpackage

// File: rtl/vram_rtag_pipe.sv
// Return-tag shift register: carries {owner, is_read, lock_rd} for RD_LAT
// cycles so the last stage lines up with the VRAM registered read data.
module vram_rtag_pipe
  import vram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] owner_in,
  input  logic       is_read_in,
  input  logic       lock_rd_in,
  output logic [1:0] owner_out,
  output logic       is_read_out,
  output logic       lock_rd_out
);

  rtag_t stage_d [RD_LAT];
  rtag_t stage_q [RD_LAT];

  always_comb begin
    stage_d[0] = '{owner: owner_e'(owner_in), is_read: is_read_in, lock_rd: lock_rd_in};
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (rst) stage_q[i] <= '0;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign owner_out   = stage_q[RD_LAT-1].owner;
  assign is_read_out = stage_q[RD_LAT-1].is_read;
  assign lock_rd_out = stage_q[RD_LAT-1].lock_rd;

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between the PPU fetcher and the CPU bus.
// Handshake: req is held until gnt; an access is taken in the cycle req && gnt.
// Optional macro VRAM_LOCK_EN: CPU lockout (no VRAM slot) while ppu_mode is drawing.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ppu_mode,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_gnt,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addrs,
  output logic [DATA_W-1:0] vram_byte,
  input  logic [DATA_W-1:0] vram_out
);

  localparam int CNT_W = 4;

  logic              lock_active;
  logic              cpu_port_req, cpu_force;
  logic              ppu_win, cpu_win, cpu_lock;
  logic [CNT_W-1:0]  starve_cnt_d, starve_cnt_q;
  logic              vram_we_d, vram_we_q;
  logic [ADDR_W-1:0] vram_addrs_d, vram_addrs_q;
  logic [DATA_W-1:0] vram_byte_d, vram_byte_q;
  logic [DATA_W-1:0] ppu_rdata_d, ppu_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;
  owner_e            tag_owner;
  logic              tag_is_read, tag_lock_rd;
  logic [1:0]        ret_owner;
  logic              ret_is_read, ret_lock_rd;
  logic              ppu_hit, cpu_hit;

`ifdef VRAM_LOCK_EN
  assign lock_active = (ppu_mode == MODE_DRAW);
`else
  logic unused_ppu_mode;
  assign unused_ppu_mode = ^ppu_mode;
  assign lock_active     = 1'b0;
`endif

  // Grants are suppressed while rst is high so nothing is accepted into a pipeline being flushed.
  always_comb begin
    cpu_port_req = cpu_req && !lock_active;
    cpu_force    = (starve_cnt_q == CNT_W'(STARVE_MAX));
    ppu_win      = !rst && ppu_req && !(cpu_port_req && cpu_force);
    cpu_win      = !rst && cpu_port_req && (!ppu_req || cpu_force);
    cpu_lock     = !rst && cpu_req && lock_active;

    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || cpu_win || lock_active) begin
      starve_cnt_d = '0;
    end else if (!cpu_force) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    vram_we_d    = 1'b0;
    vram_addrs_d = vram_addrs_q;
    vram_byte_d  = vram_byte_q;
    tag_owner    = OWN_NONE;
    tag_is_read  = 1'b0;
    if (cpu_win) begin
      vram_we_d    = cpu_we;
      vram_addrs_d = cpu_addr;
      vram_byte_d  = cpu_wdata;
      tag_owner    = OWN_CPU;
      tag_is_read  = !cpu_we;
    end else if (ppu_win) begin
      vram_addrs_d = ppu_addr;
      tag_owner    = OWN_PPU;
      tag_is_read  = 1'b1;
    end
    tag_lock_rd = cpu_lock && !cpu_we;
  end

  vram_rtag_pipe u_rtag (
    .clk         (clk),
    .rst         (rst),
    .owner_in    (tag_owner),
    .is_read_in  (tag_is_read),
    .lock_rd_in  (tag_lock_rd),
    .owner_out   (ret_owner),
    .is_read_out (ret_is_read),
    .lock_rd_out (ret_lock_rd)
  );

  // Read data is steered straight from vram_out in the return cycle; otherwise each side holds.
  always_comb begin
    ppu_hit     = (ret_owner == OWN_PPU) && ret_is_read;
    cpu_hit     = (ret_owner == OWN_CPU) && ret_is_read;
    ppu_rvalid  = ppu_hit;
    ppu_rdata   = ppu_hit ? vram_out : ppu_rdata_q;
    cpu_rvalid  = cpu_hit || ret_lock_rd;
    cpu_rdata   = cpu_rdata_q;
    if (ret_lock_rd)  cpu_rdata = DATA_W'(LOCK_RDATA);
    else if (cpu_hit) cpu_rdata = vram_out;
    ppu_rdata_d = ppu_rdata;
    cpu_rdata_d = cpu_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      vram_we_q    <= 1'b0;
      vram_addrs_q <= '0;
      vram_byte_q  <= '0;
      ppu_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      vram_we_q    <= vram_we_d;
      vram_addrs_q <= vram_addrs_d;
      vram_byte_q  <= vram_byte_d;
      ppu_rdata_q  <= ppu_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign ppu_gnt    = ppu_win;
  assign cpu_gnt    = cpu_win || cpu_lock;
  assign vram_we    = vram_we_q;
  assign vram_addrs = vram_addrs_q;
  assign vram_byte  = vram_byte_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural 1 KiB VRAM, reference arbitration model with
// a shadow memory feeding expected-data queues, vector table and corner sequences.
module tb_vram_arbiter;

  localparam int STARVE_MAX = 4;

  logic       clk = 1'b0;
  logic       rst, mem_init, mon_en;
  logic [1:0] ppu_mode;
  logic       ppu_req, ppu_gnt, ppu_rvalid;
  logic [9:0] ppu_addr;
  logic [7:0] ppu_rdata;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       vram_we;
  logic [9:0] vram_addrs;
  logic [7:0] vram_byte, vram_out;

  logic [7:0] mem [1024];
  logic [7:0] shadow [1024];
  logic [7:0] ppu_exp_q[$], cpu_exp_q[$];
  int         ppu_due_q[$], cpu_due_q[$];
  int         cyc = 0;
  int         n_vec = 0, n_fail = 0;
  int         m_starve;
  logic       m_lock, m_cport, m_force, m_pg, m_cg;

  vram_arbiter #(.ADDR_W(10), .DATA_W(8), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .ppu_mode(ppu_mode),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_gnt(ppu_gnt),
    .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vram_we(vram_we), .vram_addrs(vram_addrs), .vram_byte(vram_byte), .vram_out(vram_out)
  );

  // ---------------- clock / reset / VRAM model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic lock_on(input logic [1:0] m);
`ifdef VRAM_LOCK_EN
    return (m == 2'd3);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (vram_we) begin
      mem[vram_addrs] <= vram_byte;
    end
    vram_out <= mem[vram_addrs];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  always @(negedge clk) begin
    if (!mon_en) begin
      for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
      ppu_exp_q.delete(); ppu_due_q.delete();
      cpu_exp_q.delete(); cpu_due_q.delete();
      m_starve = 0;
    end else begin
      m_lock  = lock_on(ppu_mode);
      m_cport = cpu_req && !m_lock;
      m_force = (m_starve == STARVE_MAX);
      m_pg    = !rst && ppu_req && !(m_cport && m_force);
      m_cg    = !rst && ((m_cport && (!ppu_req || m_force)) || (cpu_req && m_lock));
      chk("ppu_gnt", ppu_gnt, m_pg);
      chk("cpu_gnt", cpu_gnt, m_cg);

      if (ppu_due_q.size() > 0 && ppu_due_q[0] == cyc) begin
        chk("ppu_rvalid", ppu_rvalid, 1);
        chk("ppu_rdata", ppu_rdata, ppu_exp_q[0]);
        void'(ppu_due_q.pop_front()); void'(ppu_exp_q.pop_front());
      end else if (ppu_rvalid) begin
        chk("ppu_rvalid_spurious", ppu_rvalid, 0);
      end
      if (cpu_due_q.size() > 0 && cpu_due_q[0] == cyc) begin
        chk("cpu_rvalid", cpu_rvalid, 1);
        chk("cpu_rdata", cpu_rdata, cpu_exp_q[0]);
        void'(cpu_due_q.pop_front()); void'(cpu_exp_q.pop_front());
      end else if (cpu_rvalid) begin
        chk("cpu_rvalid_spurious", cpu_rvalid, 0);
      end

      if (m_pg) begin
        ppu_exp_q.push_back(shadow[ppu_addr]); ppu_due_q.push_back(cyc + 2);
      end
      if (m_cg) begin
        if (m_lock) begin
          if (!cpu_we) begin cpu_exp_q.push_back(8'hFF); cpu_due_q.push_back(cyc + 2); end
        end else if (cpu_we) begin
          shadow[cpu_addr] = cpu_wdata;
        end else begin
          cpu_exp_q.push_back(shadow[cpu_addr]); cpu_due_q.push_back(cyc + 2);
        end
      end
      if (rst || !cpu_req || m_cg || m_lock) m_starve = 0;
      else if (m_starve < STARVE_MAX)       m_starve++;
      if (rst) begin
        ppu_exp_q.delete(); ppu_due_q.delete();
        cpu_exp_q.delete(); cpu_due_q.delete();
      end
    end
  end

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic cpu_op(input logic we, input logic [9:0] a, input logic [7:0] d);
    int t = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (!cpu_gnt && t < 50) begin @(negedge clk); t++; end
    chk("cpu_gnt_wait", cpu_gnt, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ppu_op(input logic [9:0] a);
    int t = 0;
    ppu_req = 1'b1; ppu_addr = a;
    @(negedge clk);
    while (!ppu_gnt && t < 50) begin @(negedge clk); t++; end
    chk("ppu_gnt_wait", ppu_gnt, 1);
    @(posedge clk); #1;
    ppu_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ppu_gnt"}, ppu_gnt, 0);
    chk({tag, "_cpu_gnt"}, cpu_gnt, 0);
    chk({tag, "_ppu_rvalid"}, ppu_rvalid, 0);
    chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_ppu_rdata"}, ppu_rdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_vram_we"}, vram_we, 0);
    chk({tag, "_vram_addrs"}, vram_addrs, 0);
    chk({tag, "_vram_byte"}, vram_byte, 0);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       p_req, c_req, c_we;
    logic [9:0] p_addr, c_addr;
    logic [7:0] c_wdata;
    logic       e_pg, e_cg;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int cpu_cnt, first_cpu;
    logic lk;
    lk = lock_on(2'd3);
    vecs[0] = '{2'd0, 0, 0, 0, 10'h000, 10'h000, 8'h00, 0, 0};
    vecs[1] = '{2'd0, 1, 0, 0, 10'h3FF, 10'h000, 8'h00, 1, 0};
    vecs[2] = '{2'd0, 0, 1, 0, 10'h000, 10'h000, 8'h00, 0, 1};
    vecs[3] = '{2'd0, 0, 1, 1, 10'h000, 10'h030, 8'h5A, 0, 1};
    vecs[4] = '{2'd0, 1, 1, 0, 10'h010, 10'h030, 8'h00, 1, 0};
    vecs[5] = '{2'd0, 1, 1, 1, 10'h030, 10'h031, 8'hC3, 1, 0};
    vecs[6] = '{2'd3, 1, 1, 0, 10'h020, 10'h031, 8'h00, 1, lk};
    vecs[7] = '{2'd0, 0, 1, 0, 10'h000, 10'h031, 8'h00, 0, 1};

    rst = 1'b1; mem_init = 1'b1; mon_en = 1'b0;
    ppu_mode = 2'd0; ppu_req = 1'b0; ppu_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;

    // write then read, data visible on the port one cycle after the grant
    cpu_op(1'b1, 10'h004, 8'h02);
    @(negedge clk);
    chk("t1_vram_we", vram_we, 1);
    chk("t1_vram_addrs", vram_addrs, 10'h004);
    chk("t1_vram_byte", vram_byte, 8'h02);
    @(posedge clk); #1;
    cpu_op(1'b0, 10'h004, 8'h00);
    idle(3);

    // vector table: grants with a cleared starvation counter
    for (int i = 0; i < 8; i++) begin
      ppu_mode = vecs[i].mode;
      ppu_req = vecs[i].p_req; ppu_addr = vecs[i].p_addr;
      cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
      cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_ppu_gnt", i), ppu_gnt, vecs[i].e_pg);
      chk($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
      @(posedge clk); #1;
      ppu_req = 1'b0; cpu_req = 1'b0;
      if (vecs[i].c_req && !vecs[i].e_cg) cpu_op(vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata);
      ppu_mode = 2'd0;
      idle(2);
    end

    // both requesting continuously: PPU 4 cycles, CPU on the 5th
    cpu_cnt = 0; first_cpu = -1;
    ppu_req = 1'b1; ppu_addr = 10'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin
        cpu_cnt++;
        if (first_cpu < 0) first_cpu = i;
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    idle(1);
    ppu_req = 1'b0;
    chk("t2_cpu_grants", cpu_cnt, 4);
    chk("t2_first_cpu", first_cpu, 4);
    idle(3);

    // back-to-back write then read of the same address
    cpu_op(1'b1, 10'h005, 8'h03);
    cpu_op(1'b0, 10'h005, 8'h00);
    idle(3);

    // drawing mode: lockout when enabled, ignored otherwise
    ppu_mode = 2'd3;
    fork
      ppu_op(10'h010);
      cpu_op(1'b1, 10'h004, 8'hAA);
    join
    fork
      ppu_op(10'h011);
      cpu_op(1'b0, 10'h004, 8'h00);
    join
    ppu_mode = 2'd0;
    cpu_op(1'b0, 10'h004, 8'h00);
    idle(3);

    // reset one cycle after a read grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
    @(negedge clk);
    chk("t5_gnt", cpu_gnt, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t5_post_reset");
    @(posedge clk); #1;
    cpu_op(1'b0, 10'h004, 8'h00);

    // idle: port quiet, address held
    idle(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_vram_we", vram_we, 0);
      chk("t6_vram_addrs", vram_addrs, 10'h004);
      @(posedge clk); #1;
    end

    idle(4);
    chk("drain_ppu_q", ppu_exp_q.size(), 0);
    chk("drain_cpu_q", cpu_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
